handshake_const_sequencer: RTL and testbench

Elastic-handshake sequencer that turns one control token into a burst of `NUM_ITERS` constant tokens: `START`, `START+STRIDE`, `START+2*STRIDE`, … It drives iteration-indexed constants, such as CORDIC shift amounts, into the loop datapath. It replaces a chain of per-iteration fixed constant units with one counter-driven source. It sits between the loop-entry control token and the consumers of the per-iteration constant.

---
 rtl/handshake_const_sequencer.sv | 58 +++++
 tb/tb_handshake_const_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/handshake_const_sequencer.sv
// handshake_const_sequencer: one control token in, a burst of NUM_ITERS constants START+i*STRIDE out.
// Define HANDSHAKE_CONST_SEQ_LAST_EN to add the outs_last burst-end marker port.
module handshake_const_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ITERS  = 16,
    parameter int CNT_WIDTH  = 5,
    parameter int START      = 0,
    parameter int STRIDE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_CONST_SEQ_LAST_EN
    ,
    output logic                  outs_last
`endif
);
    localparam logic IDLE = 1'b0;
    localparam logic EMIT = 1'b1;
    localparam logic [DATA_WIDTH-1:0] START_V  = DATA_WIDTH'(START);
    localparam logic [DATA_WIDTH-1:0] STRIDE_V = DATA_WIDTH'(STRIDE);
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(NUM_ITERS - 1);
    logic                  state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] val;
    logic                  last;
    logic                  ot;
    logic                  ct;
    assign last       = cnt == LAST_CNT;
    assign ot         = state == EMIT && outs_ready;
    // the last beat frees the slot in the same cycle so bursts chain without a bubble
    assign ctrl_ready = state == IDLE || (ot && last);
    assign ct         = ctrl_valid && ctrl_ready;
    assign outs       = val;
    assign outs_valid = state == EMIT;
`ifdef HANDSHAKE_CONST_SEQ_LAST_EN
    assign outs_last  = state == EMIT && last;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            val   <= '0;
        end else if (ct) begin
            state <= EMIT;
            cnt   <= '0;
            val   <= START_V;
        end else if (ot) begin
            state <= last ? IDLE : EMIT;
            cnt   <= last ? '0 : cnt + CNT_WIDTH'(1);
            val   <= last ? val : val + STRIDE_V;
        end
    end
endmodule

// File: tb/tb_handshake_const_sequencer.sv
// tb_handshake_const_sequencer: three sequencer configurations against a burst-index reference model.
module tb_handshake_const_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic cv   [3] = '{1'b0, 1'b0, 1'b0};
    logic ordy [3] = '{1'b1, 1'b1, 1'b1};
    logic        obs_v [3];
    logic        obs_r [3];
    logic        obs_l [3];
    logic [31:0] obs_o [3];

    int          n_it [3] = '{16, 4, 1};
    logic [31:0] st   [3] = '{32'd0, 32'd14, 32'd16};
    logic [31:0] sd   [3] = '{32'd1, 32'd3, 32'd1};
    logic [31:0] mask [3] = '{32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFFF};

    bit busy [3] = '{0, 0, 0};
    int k    [3] = '{0, 0, 0};
    bit zero [3] = '{1, 1, 1};

    logic [31:0] o0, o2;
    logic [3:0]  o1;
    logic        l0, l1, l2;

    handshake_const_sequencer u0 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(obs_r[0]),
        .outs(o0), .outs_valid(obs_v[0]), .outs_ready(ordy[0])
`ifdef HANDSHAKE_CONST_SEQ_LAST_EN
        , .outs_last(l0)
`endif
    );
    handshake_const_sequencer #(.DATA_WIDTH(4), .NUM_ITERS(4), .CNT_WIDTH(3), .START(14), .STRIDE(3)) u1 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(obs_r[1]),
        .outs(o1), .outs_valid(obs_v[1]), .outs_ready(ordy[1])
`ifdef HANDSHAKE_CONST_SEQ_LAST_EN
        , .outs_last(l1)
`endif
    );
    handshake_const_sequencer #(.NUM_ITERS(1), .START(16)) u2 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(obs_r[2]),
        .outs(o2), .outs_valid(obs_v[2]), .outs_ready(ordy[2])
`ifdef HANDSHAKE_CONST_SEQ_LAST_EN
        , .outs_last(l2)
`endif
    );

`ifndef HANDSHAKE_CONST_SEQ_LAST_EN
    assign l0 = 1'b0;
    assign l1 = 1'b0;
    assign l2 = 1'b0;
`endif
    assign obs_o[0] = o0;
    assign obs_o[1] = {28'd0, o1};
    assign obs_o[2] = o2;
    assign obs_l[0] = l0;
    assign obs_l[1] = l1;
    assign obs_l[2] = l2;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    // Checks outputs mid-cycle, then advances the model by what the edge will transfer.
    task automatic tick(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            #4;
            for (int i = 0; i < 3; i++) begin
                bit last, ot, ct, exp_r;
                logic [31:0] e;
                last  = busy[i] && k[i] == n_it[i] - 1;
                ot    = busy[i] && ordy[i];
                exp_r = !busy[i] || (ot && last);
                ct    = cv[i] && exp_r;
                e     = busy[i] ? (st[i] + 32'(k[i]) * sd[i]) & mask[i] : 32'd0;
                chk("outs_valid", i, {31'd0, obs_v[i]}, {31'd0, busy[i]});
                chk("ctrl_ready", i, {31'd0, obs_r[i]}, {31'd0, exp_r});
                if (busy[i] || zero[i]) chk("outs", i, obs_o[i], e);
`ifdef HANDSHAKE_CONST_SEQ_LAST_EN
                chk("outs_last", i, {31'd0, obs_l[i]}, {31'd0, last});
`endif
                if (rst) begin
                    busy[i] = 0;
                    k[i]    = 0;
                    zero[i] = 1;
                end else begin
                    if (ot) begin
                        if (last) begin
                            busy[i] = 0;
                            k[i]    = 0;
                        end else k[i]++;
                    end
                    if (ct) begin
                        busy[i] = 1;
                        k[i]    = 0;
                        zero[i] = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b0;
        tick(2);
        // single burst, no stall
        cv[0] = 1'b1;
        tick(1);
        cv[0] = 1'b0;
        tick(19);
        // back-to-back bursts with ctrl held high
        cv[0] = 1'b1;
        tick(34);
        cv[0] = 1'b0;
        tick(18);
        // backpressure on beats 3..6
        cv[0] = 1'b1;
        tick(1);
        cv[0] = 1'b0;
        tick(2);
        ordy[0] = 1'b0;
        tick(4);
        ordy[0] = 1'b1;
        tick(16);
        // reset after value 5 has transferred
        cv[0] = 1'b1;
        tick(1);
        cv[0] = 1'b0;
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        cv[0] = 1'b1;
        tick(1);
        cv[0] = 1'b0;
        tick(18);
        // wrap-around config and single-iteration config
        cv[1] = 1'b1;
        cv[2] = 1'b1;
        tick(1);
        cv[1] = 1'b0;
        tick(12);
        cv[2] = 1'b0;
        tick(3);
        // random handshakes with occasional reset
        for (int r = 0; r < 400; r++) begin
            for (int i = 0; i < 3; i++) begin
                cv[i]   = 1'($urandom_range(0, 1));
                ordy[i] = $urandom_range(0, 3) != 0;
            end
            rst = $urandom_range(0, 79) == 0;
            tick(1);
        end
        rst = 1'b0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
